// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RISC-V memory responder.
//   state_e      : responder FSM states (idle, latency wait, response)
//   MEMRW_*      : encoding of the memrw request bit, shared with the control plane
//   idx_width()  : word-index width for a given array depth
package rv_mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic MEMRW_READ  = 1'b0;
    localparam logic MEMRW_WRITE = 1'b1;

    function automatic int unsigned idx_width(input int unsigned depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, registered read.
// Contents and read register are not reset.
//   clk_i : clock
//   en_i  : access enable
//   we_i  : 1 = write, 0 = read (when en_i)
//   be_i  : byte enables for writes
//   idx_i : word index
//   wd_i  : write data
//   rd_o  : registered read data (updated on enabled reads only)
module rv_mem_array
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IdxW        = idx_width(DEPTH_WORDS)
) (
    input  logic            clk_i,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [3:0]      be_i,
    input  logic [IdxW-1:0] idx_i,
    input  logic [31:0]     wd_i,
    output logic [31:0]     rd_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wd_i[8*b +: 8];
                    end
                end
            end else begin
                rd_q <= mem_q[idx_i];
            end
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/rv_mem_resp.sv
// Memory responder: accepts one word-aligned read or write per handshake, serves it from an
// internal RAM after a fixed latency and completes with a one-cycle ack pulse. Misaligned or
// out-of-range accesses complete with err=1 and never touch the RAM.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   req_i   : request valid, held stable until ack
//   memrw_i : 1 = write, 0 = read
//   addr_i  : byte address
//   wdata_i : write data
//   wstrb_i : write byte enables
//   rdata_o : read data, non-zero only during ack of a successful read
//   ack_o   : one-cycle completion pulse
//   err_o   : access error, qualified by ack
//   busy_o  : request in progress
module rv_mem_resp
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        memrw_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned IdxW = idx_width(DEPTH_WORDS);
    localparam int unsigned CntW = ($clog2(LATENCY) > 0) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 2);
    // 33 bits so the byte size of a large array cannot overflow the compare.
    localparam logic [32:0] ByteLimit = 33'(DEPTH_WORDS) << 2;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic        memrw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0]     offset;
    logic [IdxW-1:0] word_idx;
    logic            acc_err;
    logic            ram_en;
    logic [31:0]     ram_rd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields are only captured on accept and held through WAIT/RESP.
    always_ff @(posedge clk_i) begin
        if (state_q == StIdle && req_i) begin
            memrw_q <= memrw_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
        end
    end

    // Subtraction wraps, so addresses below BASE_ADDR land far above the limit.
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset[IdxW+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) || ({1'b0, offset} >= ByteLimit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ram_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    // Final WAIT cycle: commit/read now; a coinciding reset drops the write.
                    ram_en  = !acc_err && !rst_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    rv_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IdxW       (IdxW)
    ) u_array (
        .clk_i(clk_i),
        .en_i (ram_en),
        .we_i (memrw_q == MEMRW_WRITE),
        .be_i (wstrb_q),
        .idx_i(word_idx),
        .wd_i (wdata_q),
        .rd_o (ram_rd)
    );

    always_comb begin
        ack_o   = (state_q == StResp);
        err_o   = ack_o && acc_err;
        busy_o  = (state_q != StIdle);
        rdata_o = '0;
        if (ack_o && !acc_err && memrw_q == MEMRW_READ) begin
            rdata_o = ram_rd;
        end
    end

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: three instances cover LATENCY=2, LATENCY=4 and a
// non-zero BASE_ADDR.
module tb_rv_mem_resp;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic        memrw [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];
    logic        busy  [3];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .memrw_i(memrw[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
        .err_o(err[0]), .busy_o(busy[0])
    );

    rv_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .memrw_i(memrw[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
        .err_o(err[1]), .busy_o(busy[1])
    );

    rv_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .memrw_i(memrw[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .rdata_o(rdata[2]), .ack_o(ack[2]),
        .err_o(err[2]), .busy_o(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full handshake on instance d; returns data, err and accept-to-ack latency.
    task automatic access(input int d, input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output logic er, output int lat);
        bit seen;
        @(posedge clk); #1;
        req[d]   = 1'b1;
        memrw[d] = rw;
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        lat  = 0;
        seen = 0;
        rd   = '0;
        er   = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[d]) begin
                seen = 1;
                rd   = rdata[d];
                er   = err[d];
            end
        end
        req[d] = 1'b0;
        if (!seen) begin
            check("ack_timeout", 32'(seen), 32'd1);
        end
        @(posedge clk); #1;
        check("ack_pulse_drop", 32'(ack[d]), 32'd0);
        check("rdata_after_ack", rdata[d], 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        int ack_cyc [3];
        int k;
        int cyc;
        int idle_cnt;
        bit ack_seen;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; memrw[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ack", 32'(ack[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'h0);
        end
        rst = 1'b0;

        // Full write then read, LATENCY=2.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_err", 32'(er), 32'd0);
        check("wr_rdata_zero", rd, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_err", 32'(er), 32'd0);
        check("rd_data", rd, 32'hDEADBEEF);

        // Partial write of byte 1.
        access(0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, rd, er, lat);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("part_data", rd, 32'hDEADABEF);

        // wstrb=0 write is a legal no-op.
        access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        check("nostrb_err", 32'(er), 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("nostrb_data", rd, 32'hDEADABEF);

        // Error cases.
        access(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'h0);
        check("mis_lat", 32'(lat), 32'd2);
        access(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'h0);
        access(0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check("mis_wr_err", 32'(er), 32'd1);
        access(0, 1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        check("oor_wr_err", 32'(er), 32'd1);
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("post_err_data", rd, 32'hDEADABEF);

        // Top word is valid.
        access(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lat);
        access(0, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        check("top_err", 32'(er), 32'd0);
        check("top_data", rd, 32'hCAFEF00D);

        // Reset during WAIT discards the write (LATENCY=2: the one WAIT cycle is the commit).
        access(0, 1'b1, 32'h20, 32'h11112222, 4'hF, rd, er, lat);
        @(posedge clk); #1;
        req[0] = 1'b1; memrw[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h5555AAAA;
        wstrb[0] = 4'hF;
        @(posedge clk); #1;
        check("rstmid_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_idle", 32'(busy[0]), 32'd0);
        ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ack[0]) ack_seen = 1;
            @(posedge clk); #1;
        end
        check("rstmid_noack", 32'(ack_seen), 32'd0);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("rstmid_data", rd, 32'h11112222);

        // LATENCY=4: preload, then back-to-back reads with req held high.
        access(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, rd, er, lat);
        check("l4_wr_lat", 32'(lat), 32'd4);
        access(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, rd, er, lat);
        access(1, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, rd, er, lat);
        @(posedge clk); #1;
        req[1] = 1'b1; memrw[1] = 1'b0; addr[1] = 32'h0;
        k = 0; cyc = 0; idle_cnt = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (k >= 1 && !busy[1]) idle_cnt++;
            if (ack[1]) begin
                case (k)
                    0: check("b2b_data0", rdata[1], 32'hA0A0A0A0);
                    1: check("b2b_data1", rdata[1], 32'hB1B1B1B1);
                    default: check("b2b_data2", rdata[1], 32'hC2C2C2C2);
                endcase
                ack_cyc[k] = cyc;
                k++;
                if (k < 3) addr[1] = 32'(4 * k);
                else req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        if (k == 3) begin
            check("b2b_first_lat", 32'(ack_cyc[0]), 32'd4);
            check("b2b_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 32'd5);
            check("b2b_gap12", 32'(ack_cyc[2] - ack_cyc[1]), 32'd5);
            check("b2b_idle", 32'(idle_cnt), 32'd2);
        end
        repeat (2) @(posedge clk);

        // BASE_ADDR = 0x8000_0000.
        access(2, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, er, lat);
        check("base_below_err", 32'(er), 32'd1);
        check("base_below_rdata", rd, 32'h0);
        access(2, 1'b1, 32'h8000_0FFC, 32'h12345678, 4'hF, rd, er, lat);
        check("base_top_wr_err", 32'(er), 32'd0);
        access(2, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, rd, er, lat);
        check("base_top_err", 32'(er), 32'd0);
        check("base_top_data", rd, 32'h12345678);
        access(2, 1'b0, 32'h8000_1000, 32'h0, 4'h0, rd, er, lat);
        check("base_above_err", 32'(er), 32'd1);
        access(2, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, rd, er, lat);
        check("base_low_abs_err", 32'(er), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_mem_resp.md
Name: rv_mem_resp

Overview:
Memory responder for the multicycle RISC-V core: the slave end of the memory request interface that the control plane drives via memrw and the datapath drives via address and write data.
- Accepts one word-aligned read or write per handshake.
- Serves it from an internal word-addressed RAM after a fixed, parameterised latency.
- Returns data with a one-cycle ack pulse.
- Flags misaligned and out-of-range accesses with err instead of touching memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, >=16)
LATENCY, 2, cycles from accept to ack (>=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req  in  1  request valid; held with fields stable until ack
memrw  in  1  1 = write, 0 = read
addr  in  32  byte address
wdata  in  32  write data
wstrb  in  4  byte enables for writes (bit i -> wdata[8i+7:8i]); ignored on reads
rdata  out  32  read data; valid only while ack=1
ack  out  1  one-cycle completion pulse
err  out  1  access error; valid only while ack=1
busy  out  1  request in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, ack=0, err=0, busy=0, rdata=0, latency counter=0. RAM contents are not reset.
- FSM states:
  - IDLE -> WAIT when req=1. Accept cycle T: capture addr, memrw, wdata, wstrb; load counter with LATENCY-2.
  - WAIT -> RESP when counter==0; otherwise decrement. RAM access is issued in the final WAIT cycle (T+LATENCY-1) from captured fields.
  - RESP: ack=1 for exactly one cycle (T+LATENCY), then -> IDLE unconditionally.
- Back-to-back: req still high in the cycle after RESP is accepted as a new request.
  - Minimum spacing is LATENCY+1 cycles between accepts.
  - req seen during WAIT/RESP is not re-sampled.
- Address decode: offset = addr - BASE_ADDR; word index = offset[log2(DEPTH_WORDS)+1:2].
- Error conditions, evaluated on captured fields:
  - addr[1:0] != 0 -> err.
  - offset >= DEPTH_WORDS*4, compared unsigned and including addr < BASE_ADDR wrap-around -> err.
  - On error: no RAM write, rdata=0, err=1 together with ack. Latency is unchanged.
- Write: at the clock edge ending cycle T+LATENCY-1, bytes with wstrb=1 update; other bytes keep their value.
  - wstrb=0 is a legal no-op write that still acks with err=0.
  - In the RESP cycle of a write, rdata=0.
- Read: RAM output is registered and presented on rdata in the RESP cycle; rdata returns to 0 when ack drops.
- A write followed by a read of the same word returns the new data. There is no hazard, because the write commits before the next accept.
- Reset mid-operation (rst during WAIT or RESP):
  - FSM returns to IDLE next cycle and no ack is produced.
  - A write whose commit edge coincides with rst=1 is discarded.
  - Earlier committed writes persist.
- Highest address word (index DEPTH_WORDS-1) is valid; the next word is err.

Decomposition:
- Package rv_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - MEMRW_READ=1'b0 and MEMRW_WRITE=1'b1 constants, shared with the control plane;
  - a function computing index width from DEPTH_WORDS.
- Sub-module rv_mem_array: single-port synchronous RAM with per-byte write enables and registered read.
  - Ports: clk, en, we, be[3:0], idx, wd, rd.
  - No reset.

Test Plan:
- LATENCY=2, write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 -> ack 2 cycles after each accept, read rdata=0xDEADBEEF, err=0.
- Partial write wstrb=4'b0010, wdata=0x0000AB00 to 0x10 (holding 0xDEADBEEF); read -> 0xDEADABEF.
- Read addr=0x13 (misaligned), and read addr=DEPTH_WORDS*4 = 0x1000 -> ack with err=1, rdata=0; a subsequent read of 0x10 is unchanged.
- LATENCY=4, req held high continuously with reads of 0x0, 0x4, 0x8 -> acks exactly 5 cycles apart, busy low for exactly one cycle between requests.
- Write 0x5555AAAA to 0x20, assert rst for one cycle during WAIT -> no ack; a later read of 0x20 returns its pre-write value.
- BASE_ADDR=0x8000_0000: read 0x7FFF_FFFC -> err=1; read 0x8000_0FFC -> err=0, returns word 1023.
